// File: rtl/mem_stage_if.sv
// Request/response and data-memory bus of the memory-stage controller.
// The controller uses the slave modport; the pipeline/memory side uses master.
interface mem_stage_if;
    logic        req_valid;
    logic        req_wr;
    logic        req_rd;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        freeze;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        addr_err;
    logic        mem_w_en;
    logic        mem_r_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_wr, req_rd, req_addr, req_wdata, mem_rdata,
        output req_ready, freeze, resp_valid, resp_rdata, addr_err,
               mem_w_en, mem_r_en, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_wr, req_rd, req_addr, req_wdata, mem_rdata,
        input  req_ready, freeze, resp_valid, resp_rdata, addr_err,
               mem_w_en, mem_r_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage requester: accepts one load/store, waits WAIT_STATES cycles, issues one
// memory cycle and returns a response strobe. Define MISALIGN_CHECK_EN to reject unaligned addresses.
module mem_stage_ctrl #(
    parameter int WAIT_STATES = 1,
    parameter int BASE_ADDR   = 1024,
    parameter int DEPTH       = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE,
        ST_RESP
    } state_t;

    localparam logic [31:0] BASE     = 32'(BASE_ADDR);
    localparam logic [31:0] LIMIT    = 32'(DEPTH * 4);
    localparam bit          NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0]  CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        op_wr;
    logic        op_err;
    logic        mem_w_en;
    logic        mem_r_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        addr_err;

    logic        accept;
    logic        range_err;
    logic [31:0] offset;

    always_comb begin
        offset    = bus.req_addr - BASE;
        range_err = (bus.req_addr < BASE) || (offset >= LIMIT);
`ifdef MISALIGN_CHECK_EN
        range_err = range_err || (bus.req_addr[1:0] != 2'b00);
`else
        range_err = range_err;
`endif
        accept    = (state == ST_IDLE) && bus.req_valid && (bus.req_wr || bus.req_rd);
    end

    // The stall must rise in the accept cycle itself, so freeze stays combinational.
    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.freeze     = accept || (state == ST_WAIT) || (state == ST_ISSUE);
    assign bus.mem_w_en   = mem_w_en;
    assign bus.mem_r_en   = mem_r_en;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = resp_rdata;
    assign bus.addr_err   = addr_err;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_wr      <= 1'b0;
            op_err     <= 1'b0;
            mem_w_en   <= 1'b0;
            mem_r_en   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            addr_err   <= 1'b0;
        end else begin
            // Strobes default low; each is raised only on entry to its one-cycle state.
            mem_w_en   <= 1'b0;
            mem_r_en   <= 1'b0;
            resp_valid <= 1'b0;
            addr_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_wr     <= bus.req_wr;
                        op_err    <= range_err;
                        mem_addr  <= offset;
                        mem_wdata <= bus.req_wdata;
                        if (NO_WAIT) begin
                            state    <= ST_ISSUE;
                            mem_w_en <= bus.req_wr && !range_err;
                            mem_r_en <= !bus.req_wr && !range_err;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state    <= ST_ISSUE;
                        mem_w_en <= op_wr && !op_err;
                        mem_r_en <= !op_wr && !op_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ISSUE: begin
                    if (!op_wr) begin
                        resp_rdata <= op_err ? 32'd0 : bus.mem_rdata;
                    end
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    addr_err   <= op_err;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: one instance with WAIT_STATES=1 and one with
// WAIT_STATES=0; expected responses are queued at request time and popped on resp_valid.
module tb_mem_stage_ctrl;

    localparam logic [31:0] BASE  = 32'd1024;
    localparam int          DEPTH = 32;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_stage_if i1 ();
    mem_stage_if i0 ();

    mem_stage_ctrl #(.WAIT_STATES(1), .BASE_ADDR(1024), .DEPTH(32)) dut1 (.clk(clk), .rst(rst), .bus(i1));
    mem_stage_ctrl #(.WAIT_STATES(0), .BASE_ADDR(1024), .DEPTH(32)) dut0 (.clk(clk), .rst(rst), .bus(i0));

    int n_checks = 0;
    int n_errors = 0;
    int wen_cnt  = 0;

    exp_t q1[$];
    exp_t q0[$];
    exp_t e1, e0;

    function automatic logic [31:0] pat(input logic [4:0] idx);
        return 32'h1000_0000 + 32'(idx) * 32'h0001_0203;
    endfunction

    // Data memory for the WAIT_STATES=1 instance; unwritten words read the preset pattern.
    bit [31:0] mem [DEPTH];
    bit [31:0] written;
    wire [4:0] idx1 = i1.mem_addr[6:2];
    assign i1.mem_rdata = written[idx1] ? mem[idx1] : pat(idx1);
    always @(posedge clk) begin
        if (i1.mem_w_en) begin
            mem[idx1]     <= i1.mem_wdata;
            written[idx1] <= 1'b1;
        end
    end

    // Read-only memory for the WAIT_STATES=0 instance.
    assign i0.mem_rdata = i0.mem_addr ^ 32'h5A5A_0000;

    bit [31:0] ref_mem [DEPTH];
    logic [31:0] last_rd1 = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (i1.mem_w_en) wen_cnt++;
            if (i1.resp_valid) begin
                if (q1.size() == 0) begin
                    check("ws1_resp_unexpected", 32'(i1.resp_valid), 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    check("ws1_rdata", i1.resp_rdata, e1.rdata);
                    check("ws1_addr_err", 32'(i1.addr_err), 32'(e1.err));
                end
            end
            if (i0.resp_valid) begin
                if (q0.size() == 0) begin
                    check("ws0_resp_unexpected", 32'(i0.resp_valid), 32'd0);
                end else begin
                    e0 = q0.pop_front();
                    check("ws0_rdata", i0.resp_rdata, e0.rdata);
                    check("ws0_addr_err", 32'(i0.addr_err), 32'(e0.err));
                end
            end
        end
    end

    function automatic logic model_err(input logic [31:0] addr);
        logic err;
        err = (addr < BASE) || ((addr - BASE) >= 32'(DEPTH * 4));
`ifdef MISALIGN_CHECK_EN
        err = err || (addr[1:0] != 2'b00);
`endif
        return err;
    endfunction

    // One full transaction on the WAIT_STATES=1 instance, checked cycle by cycle.
    task automatic do_req1(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wdata);
        logic        err;
        logic [31:0] off;
        exp_t        e;
        off = addr - BASE;
        err = model_err(addr);
        if (!wr) last_rd1 = err ? 32'd0 : ref_mem[off[6:2]];
        else if (!err) ref_mem[off[6:2]] = wdata;
        e.rdata = last_rd1;
        e.err   = err;
        q1.push_back(e);

        @(negedge clk);
        i1.req_valid = 1'b1; i1.req_wr = wr; i1.req_rd = rd;
        i1.req_addr = addr;  i1.req_wdata = wdata;
        #1;
        check("c0_ready", 32'(i1.req_ready), 32'd1);
        check("c0_freeze", 32'(i1.freeze), 32'd1);
        @(negedge clk);
        i1.req_valid = 1'b0; i1.req_wr = 1'b0; i1.req_rd = 1'b0;
        #1;
        check("c1_freeze", 32'(i1.freeze), 32'd1);
        check("c1_ready", 32'(i1.req_ready), 32'd0);
        check("c1_en", {30'd0, i1.mem_w_en, i1.mem_r_en}, 32'd0);
        @(negedge clk);
        check("c2_w_en", 32'(i1.mem_w_en), 32'(wr && !err));
        check("c2_r_en", 32'(i1.mem_r_en), 32'(!wr && !err));
        check("c2_addr", i1.mem_addr, off);
        if (wr) check("c2_wdata", i1.mem_wdata, wdata);
        check("c2_freeze", 32'(i1.freeze), 32'd1);
        @(negedge clk);
        check("c3_resp_valid", 32'(i1.resp_valid), 32'd1);
        check("c3_freeze", 32'(i1.freeze), 32'd0);
        check("c3_en", {30'd0, i1.mem_w_en, i1.mem_r_en}, 32'd0);
        check("c3_addr_hold", i1.mem_addr, off);
    endtask

    // Load on the WAIT_STATES=0 instance; hold keeps req_valid up through RESP.
    task automatic do_load0(input logic [31:0] addr, input logic hold);
        logic        err;
        exp_t        e;
        err     = model_err(addr);
        e.err   = err;
        e.rdata = err ? 32'd0 : ((addr - BASE) ^ 32'h5A5A_0000);
        i0.req_valid = 1'b1; i0.req_rd = 1'b1; i0.req_wr = 1'b0; i0.req_addr = addr;
        #1;
        check("z0_ready", 32'(i0.req_ready), 32'd1);
        check("z0_freeze", 32'(i0.freeze), 32'd1);
        q0.push_back(e);
        @(negedge clk);
        check("z1_r_en", 32'(i0.mem_r_en), 32'(!err));
        check("z1_ready", 32'(i0.req_ready), 32'd0);
        check("z1_freeze", 32'(i0.freeze), 32'd1);
        @(negedge clk);
        if (!hold) begin
            i0.req_valid = 1'b0; i0.req_rd = 1'b0;
        end
        #1;
        check("z2_resp_valid", 32'(i0.resp_valid), 32'd1);
        check("z2_ready", 32'(i0.req_ready), 32'd0);
        check("z2_freeze", 32'(i0.freeze), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(5'(i));
        i1.req_valid = 1'b0; i1.req_wr = 1'b0; i1.req_rd = 1'b0;
        i1.req_addr = '0;    i1.req_wdata = '0;
        i0.req_valid = 1'b0; i0.req_wr = 1'b0; i0.req_rd = 1'b0;
        i0.req_addr = '0;    i0.req_wdata = '0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(i1.req_ready), 32'd1);
        check("rst_freeze", 32'(i1.freeze), 32'd0);
        check("rst_resp", {29'd0, i1.resp_valid, i1.addr_err, i1.mem_w_en}, 32'd0);
        check("rst_r_en", 32'(i1.mem_r_en), 32'd0);
        check("rst_rdata", i1.resp_rdata, 32'd0);
        check("rst_addr", i1.mem_addr, 32'd0);

        do_req1(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF);
        do_req1(1'b0, 1'b1, 32'd1028, 32'h0);
        do_req1(1'b1, 1'b0, 32'd1152, 32'h1234_5678);
        do_req1(1'b0, 1'b1, 32'd1020, 32'h0);
        do_req1(1'b1, 1'b1, 32'd1032, 32'd5);
        do_req1(1'b0, 1'b1, 32'd1032, 32'h0);
        do_req1(1'b1, 1'b0, 32'd1024 + 32'd124, 32'hCAFE_F00D);
        do_req1(1'b0, 1'b1, 32'd1024 + 32'd124, 32'h0);
        do_req1(1'b0, 1'b1, 32'd1030, 32'h0);

        @(negedge clk);
        i1.req_valid = 1'b1; i1.req_wr = 1'b0; i1.req_rd = 1'b0; i1.req_addr = 32'd1028;
        #1;
        check("ign_freeze", 32'(i1.freeze), 32'd0);
        @(negedge clk);
        check("ign_ready", 32'(i1.req_ready), 32'd1);
        check("ign_freeze2", 32'(i1.freeze), 32'd0);
        check("ign_en", {30'd0, i1.mem_w_en, i1.mem_r_en}, 32'd0);
        i1.req_valid = 1'b0;

        for (int k = 0; k < 10; k++) begin
            logic wr;
            wr = 1'($urandom_range(0, 1));
            do_req1(wr, !wr, BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4, $urandom);
        end

        @(negedge clk);
        do_load0(32'd1028, 1'b1);
        check("b2b_ready", 32'(i0.req_ready), 32'd1);
        do_load0(32'd1028, 1'b0);
        do_load0(32'd1026, 1'b0);

        // Abort a store in its WAIT cycle; no enable or response may follow.
        begin
            int wen_before;
            wen_before = wen_cnt;
            @(negedge clk);
            i1.req_valid = 1'b1; i1.req_wr = 1'b1; i1.req_addr = 32'd1040; i1.req_wdata = 32'h7777_0001;
            @(negedge clk);
            i1.req_valid = 1'b0; i1.req_wr = 1'b0;
            rst = 1'b1;
            #1;
            check("abort_ready", 32'(i1.req_ready), 32'd1);
            check("abort_freeze", 32'(i1.freeze), 32'd0);
            check("abort_addr", i1.mem_addr, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check("abort_resp", 32'(i1.resp_valid), 32'd0);
                check("abort_ready_n", 32'(i1.req_ready), 32'd1);
            end
            check("abort_no_wen", 32'(wen_cnt), 32'(wen_before));
            last_rd1 = 32'd0;
        end

        do_req1(1'b0, 1'b1, 32'd1028, 32'h0);
        repeat (2) @(negedge clk);
        check("ws1_pending", 32'(q1.size()), 32'd0);
        check("ws0_pending", 32'(q0.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
